// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter with prescaler, synchronous load, wrap pulse
// and registered active-low seven-segment outputs with optional leading-zero blanking.
module bcd_counter_display #(
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 5_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [8*DIGITS-1:0]   hex,
  output logic                  wrap
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]       prescale_cnt;
  logic                step;
  logic [4*DIGITS-1:0] next_bcd;
  logic                carry;
  logic [8*DIGITS-1:0] hex_next;
  logic                higher_zero;

  function automatic logic [4*DIGITS-1:0] saturate(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Prescaler is held at zero while stopped or loading, so the next step is a full period away.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_cnt <= '0;
    end else if (load || !run) begin
      prescale_cnt <= '0;
    end else if (prescale_cnt == PS_LAST) begin
      prescale_cnt <= '0;
    end else begin
      prescale_cnt <= prescale_cnt + 1'b1;
    end
  end

  assign step = run && !load && (prescale_cnt == PS_LAST);

  // Ripple carry/borrow; a carry surviving past the top digit is exactly the wrap condition.
  always_comb begin
    next_bcd = bcd;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (up) begin
          if (bcd[4*i +: 4] == 4'd9) begin
            next_bcd[4*i +: 4] = 4'd0;
          end else begin
            next_bcd[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (bcd[4*i +: 4] == 4'd0) begin
            next_bcd[4*i +: 4] = 4'd9;
          end else begin
            next_bcd[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      bcd  <= saturate(load_value);
      wrap <= 1'b0;
    end else if (step) begin
      bcd  <= next_bcd;
      wrap <= carry;
    end else begin
      wrap <= 1'b0;
    end
  end

  // Scan from the top digit down so higher_zero tracks "this digit and all above are zero".
  always_comb begin
    hex_next    = '1;
    higher_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero && (bcd[4*i +: 4] == 4'd0);
      if (blank_lz && (i > 0) && higher_zero) begin
        hex_next[8*i +: 8] = 8'hFF;
      end else begin
        hex_next[8*i +: 8] = seg7(bcd[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex <= '1;
    end else begin
      hex <= hex_next;
    end
  end

endmodule
